fifo_sync_prog: RTL and testbench



---
 rtl/fifo_sync_prog.sv | 149 ++++++++++++++
 tb/tb_fifo_sync_prog.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_sync_prog.sv
// Single-clock FIFO with occupancy count, programmable almost-full/empty thresholds,
// sticky overflow/underflow flags and synchronous flush. Define FIFO_FWFT_EN for first-word-fall-through.
module fifo_sync_prog #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned FIFO_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr,
    input  logic                         wr_en,
    input  logic [FIFO_WIDTH-1:0]        wr_data,
    input  logic                         rd_en,
    input  logic [$clog2(FIFO_DEPTH):0]  af_thresh,
    input  logic [$clog2(FIFO_DEPTH):0]  ae_thresh,
    output logic [FIFO_WIDTH-1:0]        rd_data,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic [$clog2(FIFO_DEPTH):0]  count,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];

    logic [CW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [FIFO_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  af_q, af_d;
    logic                  ae_q, ae_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;
    logic                  wr_acc;
    logic                  rd_acc;
`ifdef FIFO_FWFT_EN
    logic                  pf_valid_q, pf_valid_d;
    logic                  pf_load;
    logic [CW-1:0]         mem_cnt;
`endif

    // Acceptance, pointer advance and flag computation from post-update occupancy
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        rd_data_d = rd_data_q;
        count_d   = count_q;
        wr_acc    = 1'b0;
        rd_acc    = 1'b0;
        ovf_d     = ovf_q | (wr_en & full_q);
        udf_d     = udf_q | (rd_en & empty_q);

        wr_acc   = !clr && wr_en && !full_q;
        wr_ptr_d = wr_ptr_q + CW'(wr_acc);
`ifdef FIFO_FWFT_EN
        // Prefetch register refills from memory whenever it is (or is about to be) vacant
        mem_cnt    = wr_ptr_q - rd_ptr_q;
        rd_acc     = !clr && rd_en && pf_valid_q;
        pf_load    = !clr && (mem_cnt != '0) && (!pf_valid_q || rd_acc);
        rd_ptr_d   = rd_ptr_q + CW'(pf_load);
        pf_valid_d = pf_load | (pf_valid_q & ~rd_acc);
        if (pf_load) begin
            rd_data_d = mem[rd_ptr_q[AW-1:0]];
        end
`else
        rd_acc   = !clr && rd_en && !empty_q;
        rd_ptr_d = rd_ptr_q + CW'(rd_acc);
        if (rd_acc) begin
            rd_data_d = mem[rd_ptr_q[AW-1:0]];
        end
`endif

        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
`ifdef FIFO_FWFT_EN
            pf_valid_d = 1'b0;
`endif
        end

`ifdef FIFO_FWFT_EN
        count_d = (wr_ptr_d - rd_ptr_d) + CW'(pf_valid_d);
        empty_d = !pf_valid_d;
`else
        count_d = wr_ptr_d - rd_ptr_d;
        empty_d = (count_d == '0);
`endif
        full_d = (count_d == CW'(FIFO_DEPTH));
        af_d   = (count_d >= af_thresh);
        ae_d   = (count_d <= ae_thresh);
    end

    // Storage: no reset so it maps onto a RAM macro
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_data_q <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            af_q      <= (af_thresh == '0);
            ae_q      <= 1'b1;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
`ifdef FIFO_FWFT_EN
            pf_valid_q <= 1'b0;
`endif
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rd_data_q <= rd_data_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
            af_q      <= af_d;
            ae_q      <= ae_d;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
`ifdef FIFO_FWFT_EN
            pf_valid_q <= pf_valid_d;
`endif
        end
    end

    assign rd_data      = rd_data_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule

// File: tb/tb_fifo_sync_prog.sv
// Self-checking bench for fifo_sync_prog: directed scenarios plus randomized traffic
// compared against a queue-based reference model (standard mode; FWFT build runs a directed check).
module tb_fifo_sync_prog;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned AW    = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             clr;
    logic             wr_en;
    logic             rd_en;
    logic [WIDTH-1:0] wr_data;
    logic [AW:0]      af_thresh;
    logic [AW:0]      ae_thresh;
    logic [WIDTH-1:0] rd_data;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [AW:0]      count;
    logic             overflow;
    logic             underflow;

    fifo_sync_prog #(.FIFO_DEPTH(DEPTH), .FIFO_WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr          (clr),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .af_thresh    (af_thresh),
        .ae_thresh    (ae_thresh),
        .rd_data      (rd_data),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: contents as a queue, sticky flags, last word read
    logic [WIDTH-1:0] q [$];
    logic             m_ovf;
    logic             m_udf;
    logic [WIDTH-1:0] m_rd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
    endtask

    task automatic model_edge();
        int n;
        n = q.size();
        if (clr) begin
            model_clear();
        end else begin
            if (wr_en && n == DEPTH) m_ovf = 1'b1;
            if (rd_en && n == 0)     m_udf = 1'b1;
            if (rd_en && n > 0)      m_rd  = q.pop_front();
            if (wr_en && n < DEPTH)  q.push_back(wr_data);
        end
    endtask

    task automatic check_all(input string ph);
        int n;
        n = q.size();
        check({ph, " count"},   32'(count),        32'(n));
        check({ph, " full"},    32'(full),         32'(n == DEPTH));
        check({ph, " empty"},   32'(empty),        32'(n == 0));
        check({ph, " afull"},   32'(almost_full),  32'(n >= int'(af_thresh)));
        check({ph, " aempty"},  32'(almost_empty), 32'(n <= int'(ae_thresh)));
        check({ph, " ovf"},     32'(overflow),     32'(m_ovf));
        check({ph, " udf"},     32'(underflow),    32'(m_udf));
        check({ph, " rd_data"}, rd_data,           m_rd);
    endtask

    task automatic step(input string ph, input logic c, input logic w, input logic r,
                        input logic [WIDTH-1:0] d);
        clr     = c;
        wr_en   = w;
        rd_en   = r;
        wr_data = d;
        @(posedge clk);
        model_edge();
        #1;
        check_all(ph);
    endtask

    task automatic fill_to(input string ph, input int n);
        for (int i = 0; i < DEPTH + 1 && q.size() < n; i++) begin
            step(ph, 1'b0, 1'b1, 1'b0, $urandom);
        end
    endtask

    task automatic drain(input string ph);
        for (int i = 0; i < DEPTH + 1 && q.size() > 0; i++) begin
            step(ph, 1'b0, 1'b0, 1'b1, '0);
        end
    endtask

    initial begin
        int         nw;
        logic       w;
        logic       r;
        logic       c;
        rst_n     = 1'b0;
        clr       = 1'b0;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        wr_data   = '0;
        af_thresh = '0;
        ae_thresh = 5'd3;
        model_clear();
        m_rd = '0;

        @(posedge clk);
        #1;
        check_all("reset");
        check("reset afull_thr0", 32'(almost_full), 32'd1);
        rst_n = 1'b1;
        af_thresh = 5'd12;

`ifdef FIFO_FWFT_EN
        step("fw idle", 1'b0, 1'b0, 1'b0, '0);
        step("fw wr", 1'b0, 1'b1, 1'b0, 32'hDEADBEEF);
        check("fw empty_e1", 32'(empty), 32'd1);
        check("fw count_e1", 32'(count), 32'd1);
        clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        @(posedge clk);
        #1;
        check("fw empty_e2", 32'(empty), 32'd0);
        check("fw rd_data",  rd_data,    32'hDEADBEEF);
        check("fw count_e2", 32'(count), 32'd1);
        rd_en = 1'b1;
        @(posedge clk);
        #1;
        check("fw empty_pop", 32'(empty), 32'd1);
        check("fw count_pop", 32'(count), 32'd0);
        check("fw udf",       32'(underflow), 32'd0);
        rd_en = 1'b0;
`else
        step("idle", 1'b0, 1'b0, 1'b0, '0);

        // Fill to full, then one write too many
        for (int i = 0; i < DEPTH; i++) begin
            step("t1 fill", 1'b0, 1'b1, 1'b0, 32'h1000 + 32'(i));
        end
        check("t1 full", 32'(full), 32'd1);
        step("t1 ovf", 1'b0, 1'b1, 1'b0, 32'hBAD0BAD0);
        check("t1 ovf_set", 32'(overflow), 32'd1);

        // Drain in order, then one read too many
        for (int i = 0; i < DEPTH; i++) begin
            step("t2 read", 1'b0, 1'b0, 1'b1, '0);
            check("t2 seq", rd_data, 32'h1000 + 32'(i));
        end
        step("t2 udf", 1'b0, 1'b0, 1'b1, '0);
        check("t2 hold", rd_data, 32'h100F);
        step("clr", 1'b1, 1'b0, 1'b0, '0);

        // Wrap-around with low occupancy
        nw = 0;
        for (int cyc = 0; cyc < 1000 && nw < 40; cyc++) begin
            w = (q.size() < 5) && ($urandom_range(0, 1) == 1);
            r = ($urandom_range(0, 2) != 0);
            if (w) nw++;
            step("t3 wrap", 1'b0, w, r, $urandom);
        end
        check("t3 writes", 32'(nw), 32'd40);
        drain("t3 drain");

        // Simultaneous read/write at full, empty and mid-level
        fill_to("t4 fill", DEPTH);
        step("t4 both_full", 1'b0, 1'b1, 1'b1, 32'h4444);
        check("t4 cnt15", 32'(count), 32'd15);
        drain("t4 drain");
        step("t4 both_empty", 1'b0, 1'b1, 1'b1, 32'h5555);
        check("t4 cnt1", 32'(count), 32'd1);
        fill_to("t4 fill7", 7);
        step("t4 both_7", 1'b0, 1'b1, 1'b1, 32'h7777);
        check("t4 cnt7", 32'(count), 32'd7);

        // Flush wins over a concurrent write
        fill_to("t5 fill9", 9);
        step("t5 clr", 1'b1, 1'b1, 1'b0, 32'h9999);
        check("t5 cnt0", 32'(count), 32'd0);

        // Randomized traffic with threshold changes, flushes and one mid-run reset
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 99) == 0) af_thresh = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 99) == 0) ae_thresh = 5'($urandom_range(0, 31));
            c = ($urandom_range(0, 59) == 0);
            w = ($urandom_range(0, 99) < ((cyc / 500) % 2 == 0 ? 70 : 35));
            r = ($urandom_range(0, 99) < ((cyc / 500) % 2 == 0 ? 35 : 70));
            step("rand", c, w, r, $urandom);
            if (cyc == 1500) begin
                rst_n = 1'b0;
                #2;
                model_clear();
                m_rd = '0;
                check_all("midrst");
                rst_n = 1'b1;
            end
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
